// File: rtl/jump_resolve_wb.sv
// jump_resolve_wb: resolves jump-FU completions into a PC redirect/flush pulse
// and, for linking jumps, a held writeback request to the common bus arbiter.
// Jump issue is back-pressured while a writeback is pending. Completions that
// arrive while the writeback is pending are dropped and latched as an error.

module jump_resolve_wb #(
    parameter int RD_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fu_finish,
    input  logic             fu_is_branch,
    input  logic             fu_cmp_res,
    input  logic [31:0]      fu_PC_jump,
    input  logic [31:0]      fu_PC_wb,
    input  logic [RD_W-1:0]  fu_rd,
    output logic             redirect_valid,
    output logic [31:0]      redirect_PC,
    output logic             flush,
    output logic             wb_req,
    output logic [RD_W-1:0]  wb_rd,
    output logic [31:0]      wb_data,
    input  logic             wb_grant,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_WB_WAIT = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;

    logic              accept_s;
    logic              taken_s;
    logic              wb_needed_s;
    logic              violation_s;
    logic              grant_s;

    logic              redirect_valid_r;
    logic [31:0]       redirect_pc_r;
    logic [RD_W-1:0]   wb_rd_r;
    logic [31:0]       wb_data_r;
    logic              err_r;
    logic [CNT_W-1:0]  branch_cnt_r;
    logic [CNT_W-1:0]  taken_cnt_r;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] one;
        one = {{(CNT_W-1){1'b0}}, 1'b1};
        if (v == {CNT_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + one;
        end
    endfunction

    // Classify the completion strobe against the current state.
    always_comb begin
        accept_s    = 1'b0;
        violation_s = 1'b0;
        grant_s     = 1'b0;
        taken_s     = fu_is_branch ? fu_cmp_res : 1'b1;
        wb_needed_s = (!fu_is_branch) && (fu_rd != {RD_W{1'b0}});
        if (state_r == ST_IDLE) begin
            accept_s = fu_finish;
        end else begin
            // Grant is only meaningful while the request is asserted (WB_WAIT).
            violation_s = fu_finish;
            grant_s     = wb_grant;
        end
    end

    // Next-state logic: enter WB_WAIT for linking jumps, leave on grant.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && wb_needed_s) begin
                    state_nxt_s = ST_WB_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WB_WAIT: begin
                if (grant_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WB_WAIT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Redirect pulse and held target; bit 0 of the target is always cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_valid_r <= 1'b0;
            redirect_pc_r    <= 32'h0000_0000;
        end else begin
            redirect_valid_r <= accept_s && taken_s;
            if (accept_s && taken_s) begin
                redirect_pc_r <= fu_PC_jump & 32'hFFFF_FFFE;
            end
        end
    end

    // Writeback payload, captured on accept and held through WB_WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_rd_r   <= {RD_W{1'b0}};
            wb_data_r <= 32'h0000_0000;
        end else if (accept_s && wb_needed_s) begin
            wb_rd_r   <= fu_rd;
            wb_data_r <= fu_PC_wb;
        end
    end

    // Sticky protocol-violation flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (violation_s) begin
            err_r <= 1'b1;
        end
    end

    // Statistics counters, updated only by accepted events.
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt_r <= {CNT_W{1'b0}};
            taken_cnt_r  <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            if (fu_is_branch) begin
                branch_cnt_r <= sat_inc(branch_cnt_r);
            end
            if (taken_s) begin
                taken_cnt_r <= sat_inc(taken_cnt_r);
            end
        end
    end

    assign redirect_valid = redirect_valid_r;
    assign flush          = redirect_valid_r;
    assign redirect_PC    = redirect_pc_r;
    assign wb_req         = (state_r == ST_WB_WAIT);
    assign busy           = (state_r == ST_WB_WAIT);
    assign wb_rd          = wb_rd_r;
    assign wb_data        = wb_data_r;
    assign err            = err_r;
    assign branch_cnt     = branch_cnt_r;
    assign taken_cnt      = taken_cnt_r;

endmodule

// File: tb/tb_jump_resolve_wb.sv
// Scoreboard bench for jump_resolve_wb. The driver applies one input vector
// per cycle, predicts the effect from the behavioural rules, and queues the
// expected redirect/writeback events with the cycle they must appear in.
// A free-running monitor compares DUT outputs on every falling edge.

module tb_jump_resolve_wb;

    logic        clk;
    logic        rst;
    logic        fu_finish;
    logic        fu_is_branch;
    logic        fu_cmp_res;
    logic [31:0] fu_PC_jump;
    logic [31:0] fu_PC_wb;
    logic [4:0]  fu_rd;
    logic        redirect_valid;
    logic [31:0] redirect_PC;
    logic        flush;
    logic        wb_req;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_grant;
    logic        busy;
    logic        err;
    logic [15:0] branch_cnt;
    logic [15:0] taken_cnt;

    jump_resolve_wb #(.RD_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .fu_finish(fu_finish), .fu_is_branch(fu_is_branch), .fu_cmp_res(fu_cmp_res),
        .fu_PC_jump(fu_PC_jump), .fu_PC_wb(fu_PC_wb), .fu_rd(fu_rd),
        .redirect_valid(redirect_valid), .redirect_PC(redirect_PC), .flush(flush),
        .wb_req(wb_req), .wb_rd(wb_rd), .wb_data(wb_data), .wb_grant(wb_grant),
        .busy(busy), .err(err), .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        int          stamp;
        logic [31:0] pc;
    } redir_t;

    typedef struct packed {
        int          stamp;
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    redir_t redir_q[$];
    wb_t    wb_q[$];

    int cyc = 0;
    int checks = 0;
    int fails = 0;
    bit mon_en = 1'b0;

    // Reference model state (what the outputs must show after the last edge).
    bit          m_busy = 1'b0;
    bit          m_err = 1'b0;
    logic [15:0] m_branch = 16'h0000;
    logic [15:0] m_taken = 16'h0000;
    logic [31:0] last_pc = 32'h0;
    wb_t         cur_wb;
    bit          prev_req = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] sat(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'h0001;
    endfunction

    // Monitor: compares every observable output against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (redir_q.size() != 0 && redir_q[0].stamp == cyc) begin
                    redir_t e;
                    e = redir_q.pop_front();
                    chk("redirect_valid", {31'h0, redirect_valid}, 32'h1);
                    chk("flush", {31'h0, flush}, 32'h1);
                    chk("redirect_PC", redirect_PC, e.pc);
                    last_pc = e.pc;
                end else begin
                    chk("redirect_valid_idle", {31'h0, redirect_valid}, 32'h0);
                    chk("flush_idle", {31'h0, flush}, 32'h0);
                    chk("redirect_PC_hold", redirect_PC, last_pc);
                end
                chk("busy", {31'h0, busy}, {31'h0, m_busy});
                chk("wb_req", {31'h0, wb_req}, {31'h0, m_busy});
                chk("err", {31'h0, err}, {31'h0, m_err});
                chk("branch_cnt", {16'h0, branch_cnt}, {16'h0, m_branch});
                chk("taken_cnt", {16'h0, taken_cnt}, {16'h0, m_taken});
                if (wb_req && !prev_req) begin
                    if (wb_q.size() == 0) begin
                        chk("wb_unexpected", 32'h1, 32'h0);
                    end else begin
                        cur_wb = wb_q.pop_front();
                        chk("wb_start_cycle", cyc, cur_wb.stamp);
                    end
                end
                if (wb_req) begin
                    chk("wb_rd", {27'h0, wb_rd}, {27'h0, cur_wb.rd});
                    chk("wb_data", wb_data, cur_wb.data);
                end
                prev_req = wb_req;
            end
        end
    end

    // Apply one cycle of stimulus and predict its effect at the coming edge.
    task automatic drive(input logic fin, input logic br, input logic cmp,
                         input logic [31:0] pcj, input logic [31:0] pcw,
                         input logic [4:0] rd, input logic gnt);
        bit          n_busy;
        bit          n_err;
        logic [15:0] n_branch;
        logic [15:0] n_taken;
        bit          taken;
        redir_t      r;
        wb_t         w;
        fu_finish = fin; fu_is_branch = br; fu_cmp_res = cmp;
        fu_PC_jump = pcj; fu_PC_wb = pcw; fu_rd = rd; wb_grant = gnt;
        n_busy = m_busy; n_err = m_err; n_branch = m_branch; n_taken = m_taken;
        if (fin) begin
            if (m_busy) begin
                n_err = 1'b1;
            end else begin
                taken = br ? cmp : 1'b1;
                if (taken) begin
                    r.stamp = cyc + 1;
                    r.pc    = pcj & 32'hFFFF_FFFE;
                    redir_q.push_back(r);
                    n_taken = sat(m_taken);
                end
                if (br) n_branch = sat(m_branch);
                if (!br && rd != 5'd0) begin
                    w.stamp = cyc + 1;
                    w.rd    = rd;
                    w.data  = pcw;
                    wb_q.push_back(w);
                    n_busy = 1'b1;
                end
            end
        end
        if (m_busy && gnt) n_busy = 1'b0;
        @(posedge clk);
        #1;
        m_busy = n_busy; m_err = n_err; m_branch = n_branch; m_taken = n_taken;
    endtask

    task automatic idle(input int n, input logic gnt);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, gnt);
    endtask

    // Synchronous reset, then explicit check that the payload outputs are cleared.
    task automatic do_reset();
        fu_finish = 1'b0; wb_grant = 1'b0; rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_busy = 1'b0; m_err = 1'b0; m_branch = 16'h0; m_taken = 16'h0;
        last_pc = 32'h0;
        redir_q.delete();
        wb_q.delete();
        @(negedge clk);
        chk("rst_wb_req", {31'h0, wb_req}, 32'h0);
        chk("rst_wb_rd", {27'h0, wb_rd}, 32'h0);
        chk("rst_wb_data", wb_data, 32'h0);
        chk("rst_redirect_PC", redirect_PC, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        @(posedge clk);
        #1;
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; fu_finish = 1'b0; fu_is_branch = 1'b0; fu_cmp_res = 1'b0;
        fu_PC_jump = 32'h0; fu_PC_wb = 32'h0; fu_rd = 5'd0; wb_grant = 1'b0;
        @(posedge clk);
        #1;
        do_reset();
        mon_en = 1'b1;

        // Taken BEQ, then a not-taken branch.
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0104, 32'h0000_0100, 5'd0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0300, 32'h0000_0200, 5'd9, 1'b0);
        idle(2, 1'b1);

        // JALR rd=5 with grant withheld three cycles.
        drive(1'b1, 1'b0, 1'b0, 32'h0000_2001, 32'h0000_1008, 5'd5, 1'b0);
        idle(3, 1'b0);
        idle(1, 1'b1);
        idle(2, 1'b0);

        // JAL rd=0: redirect only.
        drive(1'b1, 1'b0, 1'b1, 32'h0000_4000, 32'h0000_3004, 5'd0, 1'b0);
        idle(2, 1'b0);

        // Violations during WB_WAIT, including in the grant cycle.
        drive(1'b1, 1'b0, 1'b0, 32'h0000_5000, 32'h0000_4804, 5'd3, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 32'h0000_6000, 32'h0000_0000, 5'd0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 32'h0000_7000, 32'h0000_0000, 5'd4, 1'b1);
        idle(2, 1'b0);

        // Reset in the middle of a pending writeback.
        drive(1'b1, 1'b0, 1'b0, 32'h0000_8000, 32'h0000_7804, 5'd7, 1'b0);
        idle(2, 1'b0);
        do_reset();

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            logic fin;
            logic br;
            logic [4:0] rd;
            fin = ($urandom_range(0, 2) == 0);
            br  = $urandom_range(0, 1);
            rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            drive(fin, br, 1'($urandom_range(0, 1)), $urandom, $urandom, rd,
                  1'($urandom_range(0, 1)));
        end
        idle(1, 1'b1);
        idle(1, 1'b0);

        // Saturation: 2^16-1 taken jumps plus one more, from a clean state.
        do_reset();
        for (int i = 0; i < 65536; i++) begin
            drive(1'b1, 1'b1, 1'b1, 32'(i) << 2, 32'h0, 5'd0, 1'b0);
        end
        idle(2, 1'b0);
        chk("taken_cnt_saturated", {16'h0, taken_cnt}, 32'h0000_FFFF);
        chk("branch_cnt_saturated", {16'h0, branch_cnt}, 32'h0000_FFFF);

        chk("redirect_queue_drained", redir_q.size(), 32'h0);
        chk("wb_queue_drained", wb_q.size(), 32'h0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/jump_resolve_wb.md
# jump_resolve_wb

Downstream consumer of the jump functional unit in the dynamically scheduled core. Samples the jump FU's completion (`finish`, `cmp_res`, `PC_jump`, `PC_wb`) and resolves taken/not-taken. On a taken jump it drives a one-cycle PC redirect and front-end flush. For JAL/JALR it holds the link value (`PC_wb`) and requests the common writeback bus until granted, back-pressuring jump issue while the request is pending.

## Interface
Parameters:
- `RD_W`, 5, destination register index width
- `CNT_W`, 16, width of the saturating statistics counters

Ports:
- `clk` in 1: single clock; all state updates on rising edge
- `rst` in 1: synchronous, active-high reset
- `fu_finish` in 1: jump FU completion strobe, one cycle
- `fu_is_branch` in 1: 1 = conditional B-type, 0 = JAL/JALR; valid with `fu_finish`
- `fu_cmp_res` in 1: branch condition result; valid with `fu_finish`
- `fu_PC_jump` in 32: target address; valid with `fu_finish`
- `fu_PC_wb` in 32: PC+4 link value; valid with `fu_finish`
- `fu_rd` in RD_W: destination register; valid with `fu_finish`
- `redirect_valid` out 1: one-cycle pulse, load `redirect_PC` into the PC
- `redirect_PC` out 32: target with bit 0 cleared
- `flush` out 1: one-cycle pulse coincident with `redirect_valid`; kills IF/ID
- `wb_req` out 1: writeback request to the bus arbiter
- `wb_rd` out RD_W: writeback destination
- `wb_data` out 32: writeback data (link value)
- `wb_grant` in 1: arbiter grant; sampled only while `wb_req` = 1
- `busy` out 1: blocks issue of a new jump to the FU
- `err` out 1: sticky protocol-violation flag
- `branch_cnt` out CNT_W: resolved conditional branches, saturating
- `taken_cnt` out CNT_W: taken jumps of all kinds, saturating

## Operation
- States: IDLE and WB_WAIT. `busy` = (state == WB_WAIT).
- Accept: `fu_finish` = 1 in IDLE latches all `fu_*` inputs.
- taken = `fu_is_branch` ? `fu_cmp_res` : 1.
- If taken: `redirect_valid` = `flush` = 1 for exactly the next cycle; `redirect_PC` = `fu_PC_jump` & ~1. `redirect_PC` holds its value after the pulse.
- If `fu_is_branch` = 0 and `fu_rd` != 0:
  - go to WB_WAIT with `wb_req` = 1, `wb_rd` = `fu_rd`, `wb_data` = `fu_PC_wb`.
- If `fu_is_branch` = 0 and `fu_rd` = 0: no writeback; remain IDLE.
- If `fu_is_branch` = 1: no writeback; remain IDLE.
- WB_WAIT: `wb_req`, `wb_rd` and `wb_data` are held stable until `wb_grant` = 1 is sampled. Then `wb_req` drops next cycle and the state returns to IDLE.
- `fu_finish` in WB_WAIT (including the grant cycle) is a protocol violation:
  - the event is dropped: no redirect, no counter update;
  - `err` sets and stays set until `rst`.
- Counters:
  - `branch_cnt` +1 per accepted branch.
  - `taken_cnt` +1 per accepted taken event.
  - Both saturate at 2^CNT_W−1 with no wrap.
- `rst`: state IDLE. All outputs 0: `redirect_valid`, `flush`, `redirect_PC`, `wb_req`, `wb_rd`, `wb_data`, `busy`, `err`, counters. A reset during WB_WAIT abandons the pending writeback; `wb_req` is 0 the cycle after the reset edge.

## Timing
- `fu_finish` sampled at edge N → `redirect_valid`/`flush` high during cycle N+1 only.
- `wb_req` and `busy` are high from N+1.
- `wb_grant` sampled high at edge M while `wb_req` = 1 → `wb_req` = 0 and `busy` = 0 from cycle M+1. The earliest new accept is edge M+1.
- Grant present at the first `wb_req` cycle → one-cycle request: `busy` is high for exactly one cycle.
- Back-to-back branches (no WB_WAIT) are accepted every cycle. Consecutive redirect pulses are allowed; each carries its own PC.
- `wb_grant` while `wb_req` = 0 is ignored.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Taken BEQ: finish, branch = 1, cmp = 1, PC_jump = 0x0000_0104 → cycle N+1: redirect_valid = flush = 1, redirect_PC = 0x104, no wb_req; branch_cnt = 1, taken_cnt = 1.
- Not-taken branch, cmp = 0 → no redirect, no wb_req; branch_cnt +1, taken_cnt unchanged.
- JALR with rd = 5, PC_jump = 0x2001, PC_wb = 0x1008, grant withheld 3 cycles:
  - redirect_PC = 0x2000;
  - wb_req/busy high 4 cycles with wb_rd = 5, wb_data = 0x1008 stable;
  - IDLE after the grant.
- JAL with rd = 0 → redirect pulse only; wb_req and busy stay 0.
- `fu_finish` during WB_WAIT (also in the grant cycle) → err = 1 sticky, no extra redirect, counters unchanged, the pending writeback completes normally.
- `rst` asserted mid-WB_WAIT → next cycle all outputs 0. Separately: force 2^16−1 taken jumps plus one more → taken_cnt holds 0xFFFF.
